// File: rtl/set_job_issuer.sv
// set_job_issuer: queues (central, radius) jobs in a small FIFO, issues each
// one to the SET engine with a one-cycle en pulse, waits for SET's valid (or
// gives up after TIMEOUT cycles) and holds a tagged result on a valid/ready port.
// Optional checking of the result against a per-job expected candidate is
// built when SET_JOB_ISSUER_CHECK_EN is defined.
module set_job_issuer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [15:0]      job_central,
  input  logic [7:0]       job_radius,
  input  logic [3:0]       job_expect,
  output logic             set_en,
  output logic [15:0]      set_central,
  output logic [7:0]       set_radius,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [3:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             res_mismatch,
  output logic [15:0]      err_cnt,
  output logic             idle
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             state_reg;
  logic [15:0]        mem_central [DEPTH];
  logic [7:0]         mem_radius  [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [TAG_W-1:0]   tag_cnt_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic tmo_hit;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  // A held result blocks issue unless it is being drained on this same edge.
  assign pop       = (state_reg == S_IDLE) && !empty && !set_busy &&
                     (!res_valid || res_ready);
  // The counter reaches TIMEOUT on the edge where it currently holds TIMEOUT-1.
  assign tmo_hit   = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
  assign idle      = empty && (state_reg == S_IDLE) && !res_valid;

  // Job storage: plain arrays, read through the registered SET outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_central[wr_ptr_reg] <= job_central;
      mem_radius[wr_ptr_reg]  <= job_radius;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Issue/wait/result state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_timeout   <= 1'b0;
      tag_cnt_reg   <= '0;
      tag_reg       <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            state_reg   <= S_ISSUE;
            set_en      <= 1'b1;
            set_central <= mem_central[rd_ptr_reg];
            set_radius  <= mem_radius[rd_ptr_reg];
            tag_reg     <= tag_cnt_reg;
            tag_cnt_reg <= tag_cnt_reg + 1'b1;
          end
        end
        S_ISSUE: begin
          state_reg   <= S_WAIT;
          set_en      <= 1'b0;
          set_central <= '0;
          set_radius  <= '0;
          tmo_cnt_reg <= '0;
        end
        S_WAIT: begin
          if (set_valid) begin
            state_reg     <= S_IDLE;
            res_candidate <= set_candidate;
            res_tag       <= tag_reg;
            res_timeout   <= 1'b0;
            res_valid     <= 1'b1;
          end else if (tmo_hit) begin
            state_reg     <= S_IDLE;
            res_candidate <= '0;
            res_tag       <= tag_reg;
            res_timeout   <= 1'b1;
            res_valid     <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SET_JOB_ISSUER_CHECK_EN
  logic [3:0] mem_expect [DEPTH];
  logic [3:0] expect_reg;
  logic       wait_done;
  logic       mismatch_now;

  assign wait_done    = (state_reg == S_WAIT) && (set_valid || tmo_hit);
  // A timeout always counts as a mismatch.
  assign mismatch_now = !set_valid || (set_candidate != expect_reg);

  // Expected candidate travels alongside its job.
  always_ff @(posedge clk) begin
    if (push) mem_expect[wr_ptr_reg] <= job_expect;
  end

  // Latch expectation at issue; grade the result and count errors (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      expect_reg   <= '0;
      res_mismatch <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (pop) expect_reg <= mem_expect[rd_ptr_reg];
      if (wait_done) begin
        res_mismatch <= mismatch_now;
        if (mismatch_now && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  wire unused_expect = ^job_expect;
  assign res_mismatch = 1'b0;
  assign err_cnt      = '0;
`endif

endmodule

// File: doc/set_job_issuer.md
Name: set_job_issuer

Overview:
- Initiator-side driver for the SET set-counting engine.
- Queues jobs, each a 16-bit central and an 8-bit radius, in a small FIFO.
- Issues each job to SET with a one-cycle en pulse while SET is not busy, waits for SET's valid, then captures candidate.
- Presents candidate as a tagged result on a valid/ready port; sits between the host/system side and SET.

Parameters:
- DEPTH, 4: job FIFO entries; power of two, at least 2.
- TAG_W, 6: result tag width; the tag is the per-job issue sequence number.
- TIMEOUT, 1023: cycles spent in WAIT without set_valid before the job is abandoned.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- job_valid  in  1  job offered.
- job_ready  out  1  FIFO not full.
- job_central  in  16  central word passed to SET.
- job_radius  in  8  radius word passed to SET.
- job_expect  in  4  expected candidate; used only with the optional feature.
- set_en  out  1  start pulse to SET.
- set_central  out  16  central to SET; nonzero only while set_en=1.
- set_radius  out  8  radius to SET; nonzero only while set_en=1.
- set_busy  in  1  SET busy.
- set_valid  in  1  SET result strobe.
- set_candidate  in  4  SET result.
- res_valid  out  1  result held.
- res_ready  in  1  result consumer ready.
- res_candidate  out  4  captured candidate; 0 on timeout.
- res_tag  out  TAG_W  sequence number of the job.
- res_timeout  out  1  job abandoned by the timeout.
- res_mismatch  out  1  candidate differs from job_expect; feature only.
- err_cnt  out  16  mismatch/timeout count; feature only.
- idle  out  1  FIFO empty and state is IDLE.

Behaviour:
- Reset values (synchronous rst=1): state IDLE, FIFO empty, set_en=0, set_central=0, set_radius=0, res_valid=0, res_candidate=0, res_tag=0, res_timeout=0, res_mismatch=0, err_cnt=0, tag counter=0, timeout counter=0, job_ready=1, idle=1.
- Reset mid-job: everything above applies. Queued jobs and any held result are discarded. SET shares rst, so no stale valid follows.
- FIFO push and job_ready:
  - Push on job_valid & job_ready.
  - job_ready = !full, combinational from the FIFO count.
  - Push and pop in the same cycle are allowed when the FIFO is not full.
  - Read and write pointers wrap modulo DEPTH.
- State machine (all outputs registered):
  - IDLE → ISSUE when FIFO non-empty, set_busy=0 and res_valid=0, or res_valid=1 with res_ready=1 in the same cycle.
    - On that edge: pop the FIFO, load set_central/set_radius, set set_en=1, latch the current tag and expect value, increment the tag counter (wraps 2^TAG_W-1 → 0).
  - ISSUE lasts exactly 1 cycle.
    - On exit: set_en=0, set_central=0, set_radius=0, timeout counter cleared; go to WAIT.
  - WAIT → IDLE on set_valid=1.
    - Capture set_candidate into res_candidate, load res_tag, set res_timeout=0, set res_valid=1.
  - WAIT → IDLE when the timeout counter reaches TIMEOUT with no set_valid.
    - Set res_candidate=0, res_timeout=1, res_valid=1.
  - If set_valid arrives in the same cycle the timeout counter reaches TIMEOUT, set_valid wins.
- set_valid seen in IDLE or ISSUE is ignored.
- Latency:
  - Job pushed at edge t with SET idle and no result pending → set_en high from edge t+1 to edge t+2.
  - set_valid sampled at edge v → res_valid high from edge v.
- Result port:
  - res_valid stays high and res_* stay stable until res_valid & res_ready.
  - While a result is held and not being drained, no new job issues.
- idle = FIFO empty & state IDLE & !res_valid.

Optional Feature:
- Macro: SET_JOB_ISSUER_CHECK_EN.
- When defined:
  - res_mismatch = (captured candidate != latched expect), registered with res_valid.
  - A timeout forces res_mismatch=1.
  - err_cnt increments by 1 on each result with res_mismatch=1, saturating at 16'hFFFF.
- When undefined:
  - res_mismatch=0 and err_cnt=0 constantly.
  - job_expect is unused and no comparison logic is built.

Test Plan:
- Reset, then one job (central 16'h4444, radius 8'h23): set_en high for exactly 1 cycle with those values, then set_central=0 and set_radius=0. SET model returns valid with candidate 4'd9 → res_valid=1, res_candidate=9, res_tag=0, res_timeout=0.
- Push 5 jobs back-to-back with DEPTH=4 and set_busy=1: job_ready drops after the 4th push. Releasing busy issues the jobs in order with res_tag 0,1,2,3,4; the 5th is accepted once a slot frees.
- Hold res_ready=0 with 2 jobs queued: the first result stays stable and set_en stays 0. res_ready=1 for one cycle → the second job issues on that same edge.
- SET model never asserts valid: after 1023 WAIT cycles, res_valid=1, res_timeout=1, res_candidate=0. The next job then issues normally.
- Assert rst for 1 cycle during WAIT with 3 jobs queued: all outputs return to their reset values and idle=1. A set_valid arriving after reset is ignored.
- With SET_JOB_ISSUER_CHECK_EN, job_expect=4'd7 and SET returns 4'd6: res_mismatch=1 and err_cnt=1. The next job, expect 4'd3 returned as 4'd3, gives res_mismatch=0 and err_cnt stays 1.
